// File: rtl/mersenne_trial.sv
// mersenne_trial
//   Sequential trial-factoring engine. Computes 2^p mod q by left-to-right
//   square-and-multiply: for each exponent bit (MSB first) the running value
//   x is squared, reduced mod q by a bit-serial restoring reducer, then
//   doubled mod q when the exponent bit is set. Every exponent bit is scanned,
//   so latency is fixed at EXP_WIDTH*(2*WIDTH+2) cycles from the accept edge.
//   A modulus below 2 is rejected immediately with error set.
//
// Ports
//   sys_clk    : system clock, rising edge
//   sys_rst_n  : asynchronous active-low reset
//   start      : request, sampled only while idle
//   exponent   : p, captured on the accepting edge
//   modulus    : q, captured on the accepting edge
//   residue    : 2^p mod q, held until the next result
//   is_factor  : residue == 1 and no error (q divides 2^p - 1)
//   error      : modulus < 2 for the last transaction
//   busy       : high whenever not idle
//   finished   : one-cycle pulse, result valid
module mersenne_trial #(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = 32
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 start,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic [WIDTH-1:0]     residue,
  output logic                 is_factor,
  output logic                 error,
  output logic                 busy,
  output logic                 finished
);

  localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam int CNT_W = (2 * WIDTH > 1) ? $clog2(2 * WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(EXP_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    SQUARE,
    REDUCE,
    DOUBLE,
    DONE
  } state_t;

  state_t state, state_next;

  logic [EXP_WIDTH-1:0] exp_q;
  logic [WIDTH-1:0]     mod_q;
  logic [WIDTH-1:0]     x;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH:0]       rem;
  logic [CNT_W-1:0]     red_cnt;
  logic [IDX_W-1:0]     bit_idx;

  logic                 mod_bad;
  logic [WIDTH:0]       rem_shift;
  logic [WIDTH:0]       rem_red;
  logic [WIDTH:0]       dbl;
  logic [WIDTH:0]       dbl_red;
  logic [WIDTH-1:0]     x_dbl;

  // Since x < q is kept invariant, rem < q before each shift, so the shifted
  // value is < 2q and a single conditional subtract restores rem < q. The
  // same argument bounds the doubling step.
  always_comb begin
    mod_bad   = (modulus < WIDTH'(2));
    rem_shift = {rem[WIDTH-1:0], prod[2*WIDTH-1]};
    rem_red   = (rem_shift >= {1'b0, mod_q}) ? (rem_shift - {1'b0, mod_q}) : rem_shift;
    dbl       = {x, 1'b0};
    dbl_red   = (dbl >= {1'b0, mod_q}) ? (dbl - {1'b0, mod_q}) : dbl;
    x_dbl     = exp_q[bit_idx] ? dbl_red[WIDTH-1:0] : x;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    finished   = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = mod_bad ? DONE : SQUARE;
        end
      end
      SQUARE: state_next = REDUCE;
      REDUCE: begin
        if (red_cnt == CNT_LAST) begin
          state_next = DOUBLE;
        end
      end
      DOUBLE: state_next = (bit_idx == '0) ? DONE : SQUARE;
      DONE: begin
        finished   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      exp_q     <= '0;
      mod_q     <= '0;
      x         <= '0;
      prod      <= '0;
      rem       <= '0;
      red_cnt   <= '0;
      bit_idx   <= '0;
      residue   <= '0;
      is_factor <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            exp_q <= exponent;
            mod_q <= modulus;
            if (mod_bad) begin
              error     <= 1'b1;
              residue   <= '0;
              is_factor <= 1'b0;
            end else begin
              x       <= WIDTH'(1);
              bit_idx <= IDX_TOP;
            end
          end
        end
        SQUARE: begin
          prod    <= {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, x};
          rem     <= '0;
          red_cnt <= '0;
        end
        REDUCE: begin
          rem     <= rem_red;
          prod    <= {prod[2*WIDTH-2:0], 1'b0};
          red_cnt <= red_cnt + CNT_W'(1);
          if (red_cnt == CNT_LAST) begin
            x <= rem_red[WIDTH-1:0];
          end
        end
        DOUBLE: begin
          x <= x_dbl;
          if (bit_idx == '0) begin
            residue   <= x_dbl;
            is_factor <= (x_dbl == WIDTH'(1));
            error     <= 1'b0;
          end else begin
            bit_idx <= bit_idx - IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mersenne_trial.sv
module tb_mersenne_trial;

  localparam int W   = 32;
  localparam int E   = 32;
  localparam int LAT = E * (2 * W + 2);

  logic         sys_clk   = 1'b0;
  logic         sys_rst_n = 1'b0;
  logic         start     = 1'b0;
  logic [E-1:0] exponent  = '0;
  logic [W-1:0] modulus   = '0;
  logic [W-1:0] residue;
  logic         is_factor;
  logic         error;
  logic         busy;
  logic         finished;

  typedef struct {
    logic [W-1:0] res;
    logic         fac;
    logic         err;
  } exp_t;

  exp_t expq[$];
  int   vectors     = 0;
  int   miscompares = 0;

  mersenne_trial #(.WIDTH(W), .EXP_WIDTH(E)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .exponent  (exponent),
    .modulus   (modulus),
    .residue   (residue),
    .is_factor (is_factor),
    .error     (error),
    .busy      (busy),
    .finished  (finished)
  );

  always #5 sys_clk = ~sys_clk;

  // Right-to-left binary exponentiation; all operands < 2^32 so products fit.
  function automatic longint unsigned model_pow(input longint unsigned p, input longint unsigned q);
    longint unsigned r, b, e;
    if (q < 2) return 0;
    r = 1;
    b = 2 % q;
    e = p;
    while (e != 0) begin
      if (e[0]) r = (r * b) % q;
      b = (b * b) % q;
      e = e >> 1;
    end
    return r;
  endfunction

  function automatic exp_t model(input longint unsigned p, input longint unsigned q);
    exp_t m;
    if (q < 2) begin
      m.res = '0;
      m.fac = 1'b0;
      m.err = 1'b1;
    end else begin
      m.res = W'(model_pow(p, q));
      m.fac = (m.res == W'(1));
      m.err = 1'b0;
    end
    return m;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Compare process: every finished pulse must match the oldest outstanding
  // expectation; a pulse with nothing outstanding is itself a failure.
  always @(negedge sys_clk) begin : compare
    exp_t m;
    if (sys_rst_n && finished) begin
      if (expq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_finished: got 1 expected 0");
      end else begin
        m = expq.pop_front();
        chk("residue", 64'(residue), 64'(m.res));
        chk("is_factor", 64'(is_factor), 64'(m.fac));
        chk("error", 64'(error), 64'(m.err));
      end
    end
  end

  task automatic accept(input logic [E-1:0] p, input logic [W-1:0] q);
    @(negedge sys_clk);
    start    = 1'b1;
    exponent = p;
    modulus  = q;
    @(posedge sys_clk);
    expq.push_back(model(p, q));
    #1;
    start = 1'b0;
  endtask

  // Called #1 after the accepting edge; counts edges until finished is seen.
  task automatic wait_done(input int lat, input string name);
    int cyc;
    cyc = 0;
    while (!finished && cyc < LAT + 50) begin
      @(posedge sys_clk);
      #1;
      cyc++;
    end
    chk({name, "_latency"}, 64'(cyc), 64'(lat));
    @(posedge sys_clk);
    #1;
    chk({name, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic run(input logic [E-1:0] p, input logic [W-1:0] q, input int lat, input string name);
    accept(p, q);
    wait_done(lat, name);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin : stim
    int cyc;

    // Model pinned against hand-computed values.
    chk("model_p11_q23", model_pow(11, 23), 64'd1);
    chk("model_p11_q7", model_pow(11, 7), 64'd4);
    chk("model_p29_q233", model_pow(29, 233), 64'd1);
    chk("model_p64_qmax", model_pow(64, 64'hFFFF_FFFB), 64'd25);

    #1;
    chk("rst_residue", 64'(residue), 64'd0);
    chk("rst_is_factor", 64'(is_factor), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_finished", 64'(finished), 64'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    run(11, 23, LAT, "p11q23");
    chk("p11q23_res", 64'(residue), 64'd1);
    chk("p11q23_fac", 64'(is_factor), 64'd1);

    run(11, 7, LAT, "p11q7");
    chk("p11q7_res", 64'(residue), 64'd4);
    chk("p11q7_fac", 64'(is_factor), 64'd0);

    run(29, 233, LAT, "p29q233");
    chk("p29q233_res", 64'(residue), 64'd1);

    run(29, 32'hFFFF_FFFB, LAT, "p29qmax");
    chk("p29qmax_res", 64'(residue), 64'h2000_0000);

    run(64, 32'hFFFF_FFFB, LAT, "p64qmax");
    chk("p64qmax_res", 64'(residue), 64'd25);

    run(0, 5, LAT, "p0q5");
    chk("p0q5_res", 64'(residue), 64'd1);
    chk("p0q5_fac", 64'(is_factor), 64'd1);

    run(7, 1, 0, "q1");
    chk("q1_err", 64'(error), 64'd1);
    chk("q1_res", 64'(residue), 64'd0);
    run(7, 0, 0, "q0");
    chk("q0_err", 64'(error), 64'd1);

    run(3, 5, LAT, "p3q5");
    chk("p3q5_err", 64'(error), 64'd0);
    chk("p3q5_res", 64'(residue), 64'd3);

    // start held high through a whole transaction, operands changed mid-run.
    @(negedge sys_clk);
    start    = 1'b1;
    exponent = 11;
    modulus  = 7;
    @(posedge sys_clk);
    expq.push_back(model(11, 7));
    #1;
    cyc = 0;
    while (!finished && cyc < LAT + 50) begin
      @(posedge sys_clk);
      #1;
      cyc++;
      if (cyc == 100) begin
        exponent = 11;
        modulus  = 23;
      end
    end
    chk("held_latency", 64'(cyc), 64'(LAT));
    @(posedge sys_clk);
    #1;
    chk("held_idle", 64'(busy), 64'd0);
    @(posedge sys_clk);
    expq.push_back(model(11, 23));
    #1;
    chk("held_reaccept", 64'(busy), 64'd1);
    start = 1'b0;
    wait_done(LAT, "held_second");
    chk("held_second_res", 64'(residue), 64'd1);

    // Reset in the middle of REDUCE.
    accept(11, 23);
    repeat (30) @(posedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    expq.delete();
    chk("midrst_residue", 64'(residue), 64'd0);
    chk("midrst_is_factor", 64'(is_factor), 64'd0);
    chk("midrst_error", 64'(error), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_finished", 64'(finished), 64'd0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    run(11, 23, LAT, "postrst");
    chk("postrst_res", 64'(residue), 64'd1);
    chk("postrst_fac", 64'(is_factor), 64'd1);

    repeat (3) @(negedge sys_clk);
    chk("leftover_expect", 64'(expq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
